// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared types, op codes and the codec register-write table
package i2c_cfg_pkg;
  localparam logic [7:0] OP_RESET = 8'd0;
  localparam logic [7:0] OP_AAPC  = 8'd1;
  localparam logic [7:0] OP_DAPC  = 8'd2;
  localparam logic [7:0] OP_PDC   = 8'd3;
  localparam logic [7:0] OP_DAIF  = 8'd4;
  localparam logic [7:0] OP_SC    = 8'd5;
  localparam logic [7:0] OP_AC    = 8'd6;
  typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, STOP, NEXT, DONE} state_e;
  typedef enum logic [1:0] {MODE_SINGLE, MODE_TABLE, MODE_CUSTOM, MODE_RSVD} mode_e;
  // Each word is {7-bit register address, 9-bit value} for the codec
  function automatic logic [15:0] cmd_word(input logic [7:0] op);
    case (op)
      OP_RESET: cmd_word = 16'h1E00;
      OP_AAPC:  cmd_word = 16'h0812;
      OP_DAPC:  cmd_word = 16'h0A00;
      OP_PDC:   cmd_word = 16'h0C00;
      OP_DAIF:  cmd_word = 16'h0E01;
      OP_SC:    cmd_word = 16'h1000;
      OP_AC:    cmd_word = 16'h1201;
      default:  cmd_word = 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV cycles plus 2-bit quarter phase
module i2c_quarter_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_tick,
  output logic [1:0] o_phase
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  assign o_tick  = i_en && cnt_q == CW'(CLK_DIV - 1);
  assign o_phase = phase_q;
  always_comb begin
    cnt_d   = (!i_en || o_tick) ? '0 : cnt_q + 1'b1;
    phase_d = !i_en ? '0 : phase_q + {1'b0, o_tick};
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: writes codec command words over I2C as 3-byte frames,
// with NACK retry, whole-table mode and a sticky error flag
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         N_CMD     = 7,
  parameter int         MAX_RETRY = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [1:0]               i_mode,
  input  logic [$clog2(N_CMD)-1:0] i_op,
  input  logic [15:0]              i_data,
  input  logic                     i_sdat,
  output logic                     o_busy,
  output logic                     o_finished,
  output logic                     o_error,
  output logic                     o_sclk,
  output logic                     o_sdat,
  output logic                     o_oen
);
  localparam int OPW = $clog2(N_CMD);
  localparam int RW  = $clog2(MAX_RETRY + 2);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [OPW-1:0] idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic nack_q, nack_d, error_q, error_d;
  logic tick, slot_end, more, valid, scl_mid;
  logic [1:0] phase;
  logic [15:0] word;
  logic [7:0] tx_byte;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (state_q != IDLE),
    .o_tick  (tick),
    .o_phase (phase)
  );

  assign slot_end = tick && phase == 2'd3;
  assign scl_mid  = phase[0] ^ phase[1];
  assign word     = (mode_q == MODE_CUSTOM) ? data_q : cmd_word(8'(idx_q));
  assign tx_byte  = byte_q == 2'd0 ? {DEV_ADDR, 1'b0} : byte_q == 2'd1 ? word[15:8] : word[7:0];
  assign valid    = i_mode == MODE_TABLE || i_mode == MODE_CUSTOM ||
                    (i_mode == MODE_SINGLE && 32'(i_op) < N_CMD);
  // After STOP: retry on NACK while budget remains, else advance through the table
  assign more     = nack_q ? retry_q < RW'(MAX_RETRY)
                           : (mode_q == MODE_TABLE && idx_q != OPW'(N_CMD - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    data_d  = data_q;
    retry_d = retry_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    nack_d  = nack_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (i_start && valid) begin
        state_d = START;
        mode_d  = mode_e'(i_mode);
        idx_d   = i_mode == MODE_TABLE ? '0 : i_op;
        data_d  = i_data;
        retry_d = '0;
        bit_d   = '0;
        byte_d  = '0;
        nack_d  = 1'b0;
        error_d = 1'b0;
      end
      START: if (slot_end) state_d = SHIFT;
      SHIFT: if (slot_end) begin
        state_d = bit_q == 3'd7 ? ACK : SHIFT;
        bit_d   = bit_q + 3'd1;
      end
      ACK: begin
        if (tick && phase == 2'd1 && i_sdat) nack_d = 1'b1;
        if (slot_end) begin
          state_d = (nack_q || byte_q == 2'd2) ? STOP : SHIFT;
          byte_d  = byte_q + 2'd1;
        end
      end
      STOP: if (slot_end) state_d = NEXT;
      NEXT: if (!more) begin
        state_d = DONE;
        error_d = nack_q;
      end else if (slot_end) begin
        state_d = START;
        byte_d  = '0;
        nack_d  = 1'b0;
        retry_d = nack_q ? retry_q + 1'b1 : '0;
        idx_d   = nack_q ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // START holds SCL high through q2 so SDA can fall under it; STOP mirrors that
  always_comb begin
    o_sclk = 1'b1;
    o_sdat = 1'b1;
    o_oen  = 1'b1;
    case (state_q)
      START: begin
        o_sclk = phase != 2'd3;
        o_sdat = !phase[1];
      end
      SHIFT: begin
        o_sclk = scl_mid;
        o_sdat = tx_byte[3'd7 - bit_q];
      end
      ACK: begin
        o_sclk = scl_mid;
        o_oen  = 1'b0;
      end
      STOP: begin
        o_sclk = phase != 2'd0;
        o_sdat = phase[1];
      end
      default: ;
    endcase
  end

  assign o_busy     = state_q != IDLE;
  assign o_finished = state_q == DONE;
  assign o_error    = error_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      idx_q   <= '0;
      data_q  <= '0;
      retry_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      nack_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      nack_q  <= nack_d;
      error_q <= error_d;
    end
  end
endmodule
